// File: rtl/gcm_ghash_tag.sv
// Streaming GHASH and GCM tag engine: absorbs AAD then ciphertext blocks, then the length block,
// and multiplies by H one DIGIT_BITS-wide digit per cycle; tag = GHASH ^ E(K,J0).
module gcm_ghash_tag #(
  parameter int DIGIT_BITS = 8
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [0:127] i_h,
  input  logic [0:127] i_ek_j0,
  input  logic [0:63]  i_aad_size,
  input  logic [0:63]  i_text_size,
  input  logic [0:127] i_blk,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  output logic         o_busy,
  output logic [0:127] o_tag,
  output logic         o_tag_valid
);
  localparam int M    = 128 / DIGIT_BITS;
  localparam int MC_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [0:127] R_POLY = {8'he1, 120'd0};

  typedef enum logic [2:0] {IDLE, ABSORB, MULT, LEN, FINAL} state_t;
  state_t state, state_nxt;

  logic [0:127]    h_q, ek_q, y_q, x_q, z_q, v_q;
  logic [63:0]     aad_sz_q, txt_sz_q;
  logic [57:0]     na_q, nc_q, blk_cnt_q;
  logic            phase_q, data_done_q, len_pass_q;
  logic [MC_W-1:0] mcnt_q;

  logic [57:0]  na_init, nc_init;
  logic [6:0]   rem;
  logic         last_in_phase, mc_last;
  logic [0:127] keep, blk_m, z_nxt, v_nxt;

  // Block counts computed wide so that sizes near 2^64 do not wrap.
  assign na_init = 58'(({1'b0, i_aad_size} + 65'd127) >> 7);
  assign nc_init = 58'(({1'b0, i_text_size} + 65'd127) >> 7);

  assign o_blk_ready = (state == ABSORB);
  assign o_busy      = (state != IDLE);
  assign mc_last     = (mcnt_q == MC_W'(M - 1));

  // Only the first (size mod 128) bits of a phase's last block take part in the hash.
  always_comb begin
    rem           = phase_q ? txt_sz_q[6:0] : aad_sz_q[6:0];
    last_in_phase = (blk_cnt_q == ((phase_q ? nc_q : na_q) - 58'd1));
    keep          = '1;
    if (last_in_phase && (rem != 7'd0)) keep = ~({128{1'b1}} >> rem);
    blk_m         = i_blk & keep;
  end

  // One digit of the bit-serial GF(2^128) multiply; X bit 0 is consumed first.
  always_comb begin
    z_nxt = z_q;
    v_nxt = v_q;
    for (int i = 0; i < DIGIT_BITS; i++) begin
      if (x_q[i]) z_nxt = z_nxt ^ v_nxt;
      v_nxt = (v_nxt >> 1) ^ (v_nxt[127] ? R_POLY : '0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = ((na_init == '0) && (nc_init == '0)) ? LEN : ABSORB;
      ABSORB:  if (i_blk_valid) state_nxt = MULT;
      MULT:    if (mc_last) state_nxt = len_pass_q ? FINAL : (data_done_q ? LEN : ABSORB);
      LEN:     state_nxt = MULT;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      h_q         <= '0;
      ek_q        <= '0;
      y_q         <= '0;
      x_q         <= '0;
      z_q         <= '0;
      v_q         <= '0;
      aad_sz_q    <= '0;
      txt_sz_q    <= '0;
      na_q        <= '0;
      nc_q        <= '0;
      blk_cnt_q   <= '0;
      phase_q     <= 1'b0;
      data_done_q <= 1'b0;
      len_pass_q  <= 1'b0;
      mcnt_q      <= '0;
      o_tag       <= '0;
      o_tag_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_start) begin
          h_q         <= i_h;
          ek_q        <= i_ek_j0;
          aad_sz_q    <= i_aad_size;
          txt_sz_q    <= i_text_size;
          na_q        <= na_init;
          nc_q        <= nc_init;
          blk_cnt_q   <= '0;
          phase_q     <= (na_init == '0);
          data_done_q <= (na_init == '0) && (nc_init == '0);
          len_pass_q  <= 1'b0;
          y_q         <= '0;
          o_tag_valid <= 1'b0;
        end
        ABSORB: if (i_blk_valid) begin
          x_q    <= y_q ^ blk_m;
          v_q    <= h_q;
          z_q    <= '0;
          mcnt_q <= '0;
          if (last_in_phase) begin
            blk_cnt_q <= '0;
            if (!phase_q && (nc_q != '0)) phase_q <= 1'b1;
            else data_done_q <= 1'b1;
          end else begin
            blk_cnt_q <= blk_cnt_q + 58'd1;
          end
        end
        MULT: begin
          z_q    <= z_nxt;
          v_q    <= v_nxt;
          x_q    <= x_q << DIGIT_BITS;
          mcnt_q <= mcnt_q + 1'b1;
          if (mc_last) y_q <= z_nxt;
        end
        LEN: begin
          x_q        <= y_q ^ {aad_sz_q, txt_sz_q};
          v_q        <= h_q;
          z_q        <= '0;
          mcnt_q     <= '0;
          len_pass_q <= 1'b1;
        end
        FINAL: begin
          o_tag       <= y_q ^ ek_q;
          o_tag_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/gcm_ghash_tag.md
# gcm_ghash_tag

Streaming GHASH and tag engine for the GCM datapath: consumes an arbitrary number of AAD and ciphertext blocks over a valid/ready handshake and produces the 128-bit GCM tag. It is the parametrised successor of the single-block tag path in `gcm_aes`. It supports multi-block messages, bit-granular partial final blocks and a configurable multiplier width. The AES core supplies the hash subkey H and E(K,J0); this block performs no AES itself.

## Interface
- `DIGIT_BITS`, default 8: number of multiplier bits processed per cycle. Legal values are 1, 2, 4, 8, 16, 32, 64 and 128. One GF(2^128) multiply takes M = 128/DIGIT_BITS cycles.
- `clk` in 1: clock. All state updates on the rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_start` in 1: begins an instance. Sampled only in IDLE; ignored in every other state.
- `i_h` in [0:127]: hash subkey H, captured on start.
- `i_ek_j0` in [0:127]: E(K,J0), captured on start.
- `i_aad_size` in [0:63]: AAD length in bits, captured on start.
- `i_text_size` in [0:63]: ciphertext length in bits, captured on start.
- `i_blk` in [0:127]: data block; bit 0 is the first bit of the stream.
- `i_blk_valid` in 1: `i_blk` is valid.
- `o_blk_ready` out 1: block accepted on a cycle where `i_blk_valid` and `o_blk_ready` are both high.
- `o_busy` out 1: high in every state except IDLE.
- `o_tag` out [0:127]: GCM tag.
- `o_tag_valid` out 1: `o_tag` is valid.

## Operation
- States are IDLE, ABSORB, MULT, LEN and FINAL.
- Block counts: NA = ceil(aad_size/128) and NC = ceil(text_size/128). Compute each as (size+127)>>7 in 65 bits so that no overflow occurs.
- Block order: NA AAD blocks first, then NC ciphertext blocks. The block counter is 58 bits plus a phase flag.
- Masking: in the last block of each phase, bits at index ≥ (size mod 128) are forced to 0 when size mod 128 ≠ 0.
- IDLE + i_start:
  - Capture the four inputs, clear Y to 0 and clear `o_tag_valid`.
  - Next state is LEN if NA + NC = 0, otherwise ABSORB.
- ABSORB:
  - `o_blk_ready` = 1.
  - On handshake: load X = Y ⊕ masked block and V = H, clear Z, go to MULT.
- MULT runs NIST Algorithm 1, DIGIT_BITS iterations per cycle, for M cycles. Per bit i: if X[i] then Z ^= V; V = (V >> 1) ⊕ (V[127] ? 0xE1 || 0^120 : 0).
- End of MULT (last cycle):
  - Y ← Z.
  - Next state is ABSORB if blocks remain, or LEN if data blocks are finished.
  - Next state is FINAL if this MULT was the length block.
- LEN: load X = Y ⊕ (aad_size[0:63] || text_size[0:63]) and go to MULT.
- FINAL: `o_tag` ← Y ⊕ ek_j0, `o_tag_valid` ← 1, go to IDLE.
- `o_tag` and `o_tag_valid` hold until the next accepted `i_start` or reset.
- `i_blk_valid` outside ABSORB is ignored; no block is consumed.
- A new `i_start` may be accepted on the cycle after FINAL. `o_tag_valid` clears on that start.

## Timing
- Reset values: state IDLE; Y, X, Z, V, counters and `o_tag` = 0; `o_tag_valid`, `o_blk_ready` and `o_busy` = 0.
- Reset asserted mid-operation aborts the instance. All registers return to reset values on that edge, and any partial tag is discarded.
- Take edge 0 as the edge that samples `i_start`.
  - With both lengths 0: LEN is occupied during cycle 1, MULT during cycles 2..M+1, and FINAL during cycle M+2.
  - `o_tag_valid` is high after edge M+2. With DIGIT_BITS = 8 this is edge 18.
- Per data block: handshake edge, then M MULT cycles, then `o_blk_ready` is high again.
  - Steady-state throughput is one block per M+1 cycles.
- Total for N data blocks: `o_tag_valid` is high after edge (N+1)(M+1)+1, with zero valid-wait cycles.
- `o_busy` rises on edge 0 and falls on the edge that leaves FINAL, which is the same edge on which `o_tag_valid` rises.

## Test plan
- NIST GCM TC1, DIGIT_BITS = 8:
  - Stimulus: H = 66e94bd4ef8a2c3b884cfa59ca342b2e, ek_j0 = 58e2fccefa7e3061367f1d57a4e7455a, both sizes 0.
  - Required: `o_tag` = 58e2fccefa7e3061367f1d57a4e7455a, with `o_tag_valid` after edge 18.
- NIST GCM TC2:
  - Stimulus: same H and ek_j0, text_size = 128, one block 0388dace60b6a392f328c2b971b2fe78.
  - Required: `o_tag` = ab6e47d42cec13bdf53a67b21257bddf.
- Repeat TC2 with DIGIT_BITS = 1, 4 and 128.
  - Required: identical tag in every case, with latency scaling as (N+1)(M+1)+1.
- Masking:
  - Stimulus: aad_size = 8, with the AAD block set to ff00…00 in one run and ffff…ff in another.
  - Required: identical tags in both runs.
  - Required: text_size = 136 consumes exactly 2 ciphertext blocks.
- Backpressure and ignore rules:
  - Stimulus: toggle `i_blk_valid` randomly; pulse `i_start` during MULT; drive `i_blk_valid` in IDLE.
  - Required: the tag matches the no-stall run, and the extra starts and blocks are ignored.
- Reset mid-MULT:
  - Stimulus: drive `i_rst_n` = 0 for 1 cycle, then run TC2.
  - Required: all outputs at 0 after the reset edge, and the TC2 tag is correct.
